// File: rtl/timer_clk_ctrl_if.sv
// Signal bundle for timer_clk_ctrl: TCR control words, raw counter event levels,
// asynchronous external pins and the registered per-channel pulse outputs.
interface timer_clk_ctrl_if;
  logic [7:0] i_TCR_0;
  logic [7:0] i_TCR_1;
  logic       i_OVF_0;
  logic       i_OVF_1;
  logic       i_CMA_0;
  logic       i_CMA_1;
  logic       i_CMB_0;
  logic       i_CMB_1;
  logic       i_ext_clk;
  logic       i_ext_rst;
  logic [1:0] o_counter_clock;
  logic [1:0] o_CLR_TCNT;
  logic       o_comp_match_A0_final;
  logic       o_comp_match_B0_final;

  modport master (
    output i_TCR_0, i_TCR_1, i_OVF_0, i_OVF_1, i_CMA_0, i_CMA_1,
           i_CMB_0, i_CMB_1, i_ext_clk, i_ext_rst,
    input  o_counter_clock, o_CLR_TCNT, o_comp_match_A0_final, o_comp_match_B0_final
  );

  modport slave (
    input  i_TCR_0, i_TCR_1, i_OVF_0, i_OVF_1, i_CMA_0, i_CMA_1,
           i_CMB_0, i_CMB_1, i_ext_clk, i_ext_rst,
    output o_counter_clock, o_CLR_TCNT, o_comp_match_A0_final, o_comp_match_B0_final
  );
endinterface

// File: rtl/timer_clk_ctrl.sv
// Two-channel timer clock/clear controller: prescaler taps, cascade and external
// count sources selected by CKS, clear sources by CCLR, all outputs registered one-cycle pulses.
module timer_clk_ctrl (
  input  logic             i_clk_sys,
  input  logic             i_rst,
  timer_clk_ctrl_if.slave  bus
);

  logic [5:0] psc;
  logic       tap2, tap8, tap64;

  logic ext_clk_s1, ext_clk_s2, ext_clk_h;
  logic ext_rst_s1, ext_rst_s2, ext_rst_h;
  logic ext_clk_rise, ext_clk_fall, ext_rst_rise;

  // Level vector order: {cmb1, cmb0, cma1, cma0, ovf1, ovf0}
  logic [5:0] lvl, lvl_h, lvl_rise;
  logic       ovf0_rise, ovf1_rise, cma0_rise, cma1_rise, cmb0_rise, cmb1_rise;

  logic [2:0] cks0, cks1;
  logic [1:0] cclr0, cclr1;
  logic       cascade_loop;
  logic [1:0] cnt_src, clr_src;
  logic       cma0_out_src, cmb0_out_src;

  logic [1:0] cnt_q, clr_q;
  logic       cma0_q, cmb0_q;

  logic       unused_ok;

  function automatic logic count_sel(input logic [2:0] cks, input logic cascade_ev,
                                     input logic t2, input logic t8, input logic t64,
                                     input logic er, input logic ef);
    logic r;
    r = 1'b0;
    case (cks)
      3'b000:  r = 1'b0;
      3'b001:  r = t2;
      3'b010:  r = t8;
      3'b011:  r = t64;
      3'b100:  r = cascade_ev;
      3'b101:  r = er;
      3'b110:  r = ef;
      default: r = er | ef;
    endcase
    return r;
  endfunction

  function automatic logic clear_sel(input logic [1:0] cclr, input logic a_rise,
                                     input logic b_rise, input logic x_rise);
    logic r;
    r = 1'b0;
    case (cclr)
      2'b00:   r = 1'b0;
      2'b01:   r = a_rise;
      2'b10:   r = b_rise;
      default: r = x_rise;
    endcase
    return r;
  endfunction

  assign lvl = {bus.i_CMB_1, bus.i_CMB_0, bus.i_CMA_1, bus.i_CMA_0, bus.i_OVF_1, bus.i_OVF_0};

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      psc        <= 6'd0;
      ext_clk_s1 <= 1'b0;
      ext_clk_s2 <= 1'b0;
      ext_clk_h  <= 1'b0;
      ext_rst_s1 <= 1'b0;
      ext_rst_s2 <= 1'b0;
      ext_rst_h  <= 1'b0;
      lvl_h      <= 6'd0;
      cnt_q      <= 2'b00;
      clr_q      <= 2'b00;
      cma0_q     <= 1'b0;
      cmb0_q     <= 1'b0;
    end else begin
      psc        <= psc + 6'd1;
      ext_clk_s1 <= bus.i_ext_clk;
      ext_clk_s2 <= ext_clk_s1;
      ext_clk_h  <= ext_clk_s2;
      ext_rst_s1 <= bus.i_ext_rst;
      ext_rst_s2 <= ext_rst_s1;
      ext_rst_h  <= ext_rst_s2;
      lvl_h      <= lvl;
      cnt_q      <= cnt_src & ~clr_src;
      clr_q      <= clr_src;
      cma0_q     <= cma0_out_src;
      cmb0_q     <= cmb0_out_src;
    end
  end

  always_comb begin
    tap2  = psc[0];
    tap8  = (psc[2:0] == 3'b111);
    tap64 = (psc == 6'd63);

    ext_clk_rise = ext_clk_s2 & ~ext_clk_h;
    ext_clk_fall = ~ext_clk_s2 & ext_clk_h;
    ext_rst_rise = ext_rst_s2 & ~ext_rst_h;

    lvl_rise  = lvl & ~lvl_h;
    ovf0_rise = lvl_rise[0];
    ovf1_rise = lvl_rise[1];
    cma0_rise = lvl_rise[2];
    cma1_rise = lvl_rise[3];
    cmb0_rise = lvl_rise[4];
    cmb1_rise = lvl_rise[5];

    cks0  = bus.i_TCR_0[2:0];
    cks1  = bus.i_TCR_1[2:0];
    cclr0 = bus.i_TCR_0[4:3];
    cclr1 = bus.i_TCR_1[4:3];

    // Each channel cascading off the other would be a combinational count loop.
    cascade_loop = (cks0 == 3'b100) && (cks1 == 3'b100);

    cnt_src[0] = count_sel(cks0, ovf1_rise, tap2, tap8, tap64, ext_clk_rise, ext_clk_fall)
                 & ~cascade_loop;
    cnt_src[1] = count_sel(cks1, cma0_rise, tap2, tap8, tap64, ext_clk_rise, ext_clk_fall)
                 & ~cascade_loop;

    clr_src[0] = clear_sel(cclr0, cma0_rise, cmb0_rise, ext_rst_rise);
    clr_src[1] = clear_sel(cclr1, cma1_rise, cmb1_rise, ext_rst_rise);

    cma0_out_src = cma0_rise & (cks0 != 3'b000);
    cmb0_out_src = cmb0_rise & (cks0 != 3'b000);
  end

  assign bus.o_counter_clock       = cnt_q;
  assign bus.o_CLR_TCNT            = clr_q;
  assign bus.o_comp_match_A0_final = cma0_q;
  assign bus.o_comp_match_B0_final = cmb0_q;

  // Channel 0 overflow has no consumer here and TCR[7:5] belong to other blocks.
  assign unused_ok = ^{ovf0_rise, bus.i_TCR_0[7:5], bus.i_TCR_1[7:5]};

endmodule

// File: tb/tb_timer_clk_ctrl.sv
// Directed bench for timer_clk_ctrl: reset/release timing, prescaler taps, clears,
// cascade, external edges and mid-stream reset, all against hand-derived cycle counts.
module tb_timer_clk_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_clk_ctrl_if bus();

  timer_clk_ctrl dut (
    .i_clk_sys (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int cnt0, cnt1, clr0, clr1, a0, b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_tcr(input logic [2:0] cks0, input logic [1:0] cclr0,
                         input logic [2:0] cks1, input logic [1:0] cclr1);
    bus.i_TCR_0 = {3'b000, cclr0, cks0};
    bus.i_TCR_1 = {3'b000, cclr1, cks1};
  endtask

  task automatic drop_inputs();
    bus.i_OVF_0 = 1'b0; bus.i_OVF_1 = 1'b0;
    bus.i_CMA_0 = 1'b0; bus.i_CMA_1 = 1'b0;
    bus.i_CMB_0 = 1'b0; bus.i_CMB_1 = 1'b0;
    bus.i_ext_clk = 1'b0; bus.i_ext_rst = 1'b0;
  endtask

  task automatic clear_tally();
    cnt0 = 0; cnt1 = 0; clr0 = 0; clr1 = 0; a0 = 0; b0 = 0;
  endtask

  // Step n cycles, counting pulses seen on each output after every edge.
  task automatic tally(input int n);
    repeat (n) begin
      step();
      cnt0 += int'(bus.o_counter_clock[0]);
      cnt1 += int'(bus.o_counter_clock[1]);
      clr0 += int'(bus.o_CLR_TCNT[0]);
      clr1 += int'(bus.o_CLR_TCNT[1]);
      a0   += int'(bus.o_comp_match_A0_final);
      b0   += int'(bus.o_comp_match_B0_final);
    end
  endtask

  // Called right after rst drops with CKS_0=001: prescaler is 0 in cycle 1,
  // the div2 tap fires in cycle 2 and shows on the output in cycle 3.
  task automatic check_release(input string tag);
    step(); check({tag, "_c2"}, 32'(bus.o_counter_clock[0]), 0);
    step(); check({tag, "_c3"}, 32'(bus.o_counter_clock[0]), 1);
    step(); check({tag, "_c4"}, 32'(bus.o_counter_clock[0]), 0);
    step(); check({tag, "_c5"}, 32'(bus.o_counter_clock[0]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, gaps, n;
    bit found;

    rst = 1'b1;
    set_tcr(3'b001, 2'b00, 3'b000, 2'b00);
    drop_inputs();
    step(3);
    check("reset_outs", 32'({bus.o_counter_clock, bus.o_CLR_TCNT,
                             bus.o_comp_match_A0_final, bus.o_comp_match_B0_final}), 0);
    rst = 1'b0;
    check_release("release");

    // Scenario 1: div8 on channel 0, channel 1 stopped
    set_tcr(3'b010, 2'b00, 3'b000, 2'b00);
    step();
    last = -1; gaps = 0; n = 0; clear_tally();
    for (int i = 0; i < 64; i++) begin
      step();
      if (bus.o_counter_clock[0]) begin
        n++;
        if (last >= 0 && (i - last) != 8) gaps++;
        last = i;
      end
      if (bus.o_counter_clock[1]) cnt1++;
    end
    check("s1_div8_count", 32'(n), 8);
    check("s1_div8_gaps", 32'(gaps), 0);
    check("s1_ch1_idle", 32'(cnt1), 0);

    // Scenario 2: align a CMA_0 rise with the div64 tap so the clear wins
    set_tcr(3'b011, 2'b01, 3'b000, 2'b00);
    step();
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (bus.o_counter_clock[0]) found = 1'b1;
    end
    check("s2_div64_seen", 32'(found), 1);
    if (found) begin
      step(63);
      bus.i_CMA_0 = 1'b1;
      step();
      check("s2_clr0", 32'(bus.o_CLR_TCNT[0]), 1);
      check("s2_cnt_suppressed", 32'(bus.o_counter_clock[0]), 0);
      check("s2_cma_final", 32'(bus.o_comp_match_A0_final), 1);
      check("s2_cmb_final", 32'(bus.o_comp_match_B0_final), 0);
      clear_tally();
      tally(4);
      bus.i_CMA_0 = 1'b0;
      tally(3);
      check("s2_clr_once", 32'(clr0), 0);
      check("s2_cma_once", 32'(a0), 0);
    end

    // Compare-match outputs are gated off while channel 0 is stopped
    set_tcr(3'b000, 2'b00, 3'b000, 2'b00);
    step();
    bus.i_CMA_0 = 1'b1;
    step();
    check("s2_gate_a0", 32'(bus.o_comp_match_A0_final), 0);
    bus.i_CMA_0 = 1'b0;

    // CMB clear path on channel 0, level held high
    set_tcr(3'b001, 2'b10, 3'b000, 2'b00);
    step();
    bus.i_CMB_0 = 1'b1;
    step();
    check("cmb_b0_final", 32'(bus.o_comp_match_B0_final), 1);
    check("cmb_clr0", 32'(bus.o_CLR_TCNT[0]), 1);
    step();
    check("cmb_b0_held", 32'(bus.o_comp_match_B0_final), 0);
    check("cmb_clr0_held", 32'(bus.o_CLR_TCNT[0]), 0);
    bus.i_CMB_0 = 1'b0;

    // Scenario 3: cascade
    set_tcr(3'b000, 2'b00, 3'b100, 2'b00);
    step(2);
    clear_tally();
    repeat (3) begin
      bus.i_CMA_0 = 1'b1; tally(2);
      bus.i_CMA_0 = 1'b0; tally(2);
    end
    check("s3_ch1_cascade", 32'(cnt1), 3);
    check("s3_ch0_idle", 32'(cnt0), 0);

    set_tcr(3'b100, 2'b00, 3'b000, 2'b00);
    step(2);
    clear_tally();
    repeat (2) begin
      bus.i_OVF_1 = 1'b1; tally(2);
      bus.i_OVF_1 = 1'b0; tally(2);
    end
    check("s3_ch0_cascade", 32'(cnt0), 2);

    set_tcr(3'b100, 2'b00, 3'b100, 2'b00);
    step(2);
    clear_tally();
    repeat (3) begin
      bus.i_OVF_1 = 1'b1; bus.i_CMA_0 = 1'b1; tally(2);
      bus.i_OVF_1 = 1'b0; bus.i_CMA_0 = 1'b0; tally(2);
    end
    check("s3_loop_ch0", 32'(cnt0), 0);
    check("s3_loop_ch1", 32'(cnt1), 0);

    // Scenario 4: both external clock edges, 3-cycle latency each
    set_tcr(3'b111, 2'b00, 3'b000, 2'b00);
    step(2);
    exp_q.delete();
    n = 0;
    for (int c = 0; c < 48; c++) begin
      if (bus.o_counter_clock[0]) begin
        n++;
        if (exp_q.size() > 0) check("s4_edge_time", 32'(c), exp_q.pop_front());
        else check("s4_extra_pulse", 1, 0);
      end
      if (c < 40 && (c % 5) == 0) begin
        bus.i_ext_clk = ~bus.i_ext_clk;
        exp_q.push_back(32'(c + 3));
      end
      step();
    end
    check("s4_count", 32'(n), 8);
    check("s4_pending", 32'(exp_q.size()), 0);

    // Scenario 5: external reset clears channel 1 once
    set_tcr(3'b000, 2'b00, 3'b000, 2'b11);
    step(2);
    exp_q.delete();
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.o_CLR_TCNT[1]) begin
        n++;
        if (exp_q.size() > 0) check("s5_clr_time", 32'(c), exp_q.pop_front());
        else check("s5_extra_clr", 1, 0);
      end
      if (c == 0) begin
        bus.i_ext_rst = 1'b1;
        exp_q.push_back(32'd3);
      end
      step();
    end
    check("s5_count", 32'(n), 1);
    bus.i_ext_rst = 1'b0;
    clear_tally();
    tally(6);
    check("s5_fall_no_clr", 32'(clr1), 0);

    // Scenario 6: reset mid-stream discards a pending clear and restarts the prescaler
    set_tcr(3'b001, 2'b01, 3'b000, 2'b00);
    step(5);
    bus.i_CMA_0 = 1'b1;
    rst = 1'b1;
    step();
    check("s6_rst_outs", 32'({bus.o_counter_clock, bus.o_CLR_TCNT,
                              bus.o_comp_match_A0_final, bus.o_comp_match_B0_final}), 0);
    bus.i_CMA_0 = 1'b0;
    step();
    check("s6_rst_hold", 32'({bus.o_counter_clock, bus.o_CLR_TCNT,
                              bus.o_comp_match_A0_final, bus.o_comp_match_B0_final}), 0);
    rst = 1'b0;
    check_release("s6_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_clk_ctrl.md
TIMER_CLK_CTRL -- requirements
Module: timer_clk_ctrl

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_clk_sys  in  1  system clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_TCR_0  in  8  channel 0 TCR; [2:0] CKS clock select, [4:3] CCLR clear select
- i_TCR_1  in  8  channel 1 TCR, same fields
- i_OVF_0, i_OVF_1  in  1 each  raw counter overflow level per channel
- i_CMA_0, i_CMA_1  in  1 each  raw compare-match-A level per channel
- i_CMB_0, i_CMB_1  in  1 each  raw compare-match-B level per channel
- i_ext_clk  in  1  asynchronous external count input (TMCI)
- i_ext_rst  in  1  asynchronous external counter-reset input (TMRI)
- o_counter_clock  out  2  one-cycle count-enable pulse; bit n = channel n
- o_CLR_TCNT  out  2  one-cycle counter clear pulse; bit n = channel n
- o_comp_match_A0_final  out  1  one-cycle CMA pulse, channel 0
- o_comp_match_B0_final  out  1  one-cycle CMB pulse, channel 0

Function
REQ-003 SHALL hold a free-running 6-bit prescaler, +1 every cycle, wrapping 63->0.
REQ-004 SHALL derive tap pulses: div2 when prescaler[0]==1; div8 when prescaler[2:0]==7; div64 when prescaler[5:0]==63.
REQ-005 SHALL synchronise i_ext_clk and i_ext_rst, each through two flops plus one history flop for edge detection (rise = sync & ~hist, fall = ~sync & hist).
REQ-006 SHALL edge-detect each raw level input (OVF, CMA, CMB, both channels) into one-cycle rise pulses using one history flop each.
REQ-007 SHALL select the count source per channel from CKS:
- 000: stopped, no pulses
- 001: div2
- 010: div8
- 011: div64
- 100: cascade; ch0 counts on ch1 OVF rise, ch1 counts on ch0 CMA rise
- 101: ext clock rise
- 110: ext clock fall
- 111: either ext edge
REQ-008 SHALL register o_counter_clock[n], so the pulse appears one cycle after the selected source event.
REQ-009 SHALL produce no pulses on either channel when both CKS==100 (cascade loop).
REQ-010 SHALL select the clear source per channel from CCLR:
- 00: none
- 01: CMA rise of own channel
- 10: CMB rise of own channel
- 11: synchronised i_ext_rst rise
REQ-011 SHALL register o_CLR_TCNT[n], so the pulse appears one cycle after the source rise and is exactly one cycle long per rise.
REQ-012 SHALL suppress o_counter_clock[n] in any cycle where o_CLR_TCNT[n] is asserted (clear has priority).
REQ-013 SHALL drive o_comp_match_A0_final / o_comp_match_B0_final as registered CMA_0 / CMB_0 rise pulses, one cycle after the rise, gated off when channel 0 CKS==000.
REQ-014 SHALL sample TCR changes every cycle; a CKS change takes effect on the next source event with no partial or glitched pulse.
REQ-015 SHALL never assert any output for more than one consecutive cycle per source event. A level held high yields one pulse.

Reset
REQ-016 SHALL, while i_rst==1, clear the prescaler, all synchroniser and history flops, and all outputs to 0.
REQ-017 SHALL reset synchronously only, taking effect at the clock edge on which i_rst is sampled high. Mid-operation reset discards pending pulses.
REQ-018 SHALL start the prescaler at 0 on the first cycle after reset release; the first div2 pulse is registered out on cycle 3 after release.

Verification
REQ-019 SHALL pass these directed scenarios:
- Scenario 1: CKS_0=010 for 64 cycles -> exactly 8 o_counter_clock[0] pulses, 8 cycles apart; CKS_1=000 -> bit 1 stays 0.
- Scenario 2: CKS_0=011, CCLR_0=01, then i_CMA_0 held high 5 cycles -> one o_CLR_TCNT[0] pulse, one o_comp_match_A0_final pulse, each 1 cycle after the rise; a coincident count pulse is suppressed.
- Scenario 3: CKS_1=100, i_CMA_0 toggled 3 times -> 3 o_counter_clock[1] pulses. With both CKS=100, toggling i_OVF_1 and i_CMA_0 -> no pulses.
- Scenario 4: CKS_0=111, i_ext_clk square wave of period 10 cycles for 40 cycles -> 8 pulses, each 3 cycles after the corresponding edge.
- Scenario 5: CCLR_1=11, i_ext_rst rises -> o_CLR_TCNT[1] pulses once, 3 cycles later. i_ext_rst held high -> no further pulses.
- Scenario 6: i_rst asserted mid-stream with CKS_0=001 -> all outputs 0 from the next edge; after release, the prescaler restarts at 0 and the timing of REQ-018 holds.
